btn_debounce_scheduler: RTL and testbench

BTN_DEBOUNCE_SCHEDULER -- requirements
Module: btn_debounce_scheduler

---
 rtl/btn_debounce_if.sv | 21 ++
 rtl/btn_debounce_scheduler.sv | 119 +++++++++++
 tb/tb_btn_debounce_scheduler.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/btn_debounce_if.sv
// Button debounce bus: raw buttons and sample strobe in, debounced levels,
// edge pulses and scheduler status out.
interface btn_debounce_if;
    logic [3:0] btn;
    logic       tick_en;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic       busy;
    logic [1:0] active_idx;

    modport master (
        output btn, tick_en,
        input  btn_level, btn_press, btn_release, busy, active_idx
    );

    modport slave (
        input  btn, tick_en,
        output btn_level, btn_press, btn_release, busy, active_idx
    );
endinterface

// File: rtl/btn_debounce_scheduler.sv
// Four-button debouncer sharing one counter, granted round-robin to one button at a time.
// Define BTN_SYNC_EN to put a two-flop synchronizer on every raw button bit.
module btn_debounce_scheduler #(
    parameter int unsigned DEBOUNCE_LEN = 4
) (
    input  logic           clk,
    input  logic           rst,
    btn_debounce_if.slave  bus
);
    typedef enum logic {IDLE, COUNT} state_t;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [1:0]  idx_q, idx_d;
    logic [3:0]  level_q, level_d;
    logic [3:0]  press_q, press_d;
    logic [3:0]  release_q, release_d;
    logic [3:0]  s_btn;

`ifdef BTN_SYNC_EN
    logic [3:0] sync1_q, sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= bus.btn;
            sync2_q <= sync1_q;
        end
    end

    assign s_btn = sync2_q;
`else
    assign s_btn = bus.btn;
`endif

    logic [3:0]  pending;
    logic [1:0]  cand;
    logic        found;
    logic [15:0] cnt_inc;

    assign pending = s_btn ^ level_q;
    assign cnt_inc = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        idx_d     = idx_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        cand      = '0;
        found     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // First pending button at or after the round-robin pointer wins.
                for (int k = 0; k < 4; k++) begin
                    cand = ptr_q + 2'(k);
                    if (!found && pending[cand]) begin
                        found = 1'b1;
                        idx_d = cand;
                    end
                end
                if (found) begin
                    cnt_d   = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (s_btn[idx_q] == level_q[idx_q]) begin
                    cnt_d   = '0;
                    ptr_d   = idx_q + 2'd1;
                    state_d = IDLE;
                end else if (bus.tick_en) begin
                    if (cnt_inc == 16'(DEBOUNCE_LEN)) begin
                        level_d[idx_q] = ~level_q[idx_q];
                        press_d[idx_q]   = ~level_q[idx_q];
                        release_d[idx_q] = level_q[idx_q];
                        ptr_d   = idx_q + 2'd1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
    assign bus.busy        = (state_q == COUNT);
    assign bus.active_idx  = (state_q == COUNT) ? idx_q : ptr_q;
endmodule

// File: tb/tb_btn_debounce_scheduler.sv
// Bench for btn_debounce_scheduler: directed scenarios plus random bouncing,
// every cycle compared against a behavioural scheduler model.
module tb_btn_debounce_scheduler;
    localparam int LEN = 4;

    logic clk = 1'b0;
    logic rst;
    btn_debounce_if bif ();

    btn_debounce_scheduler #(.DEBOUNCE_LEN(LEN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: owner = -1 means nobody holds the shared counter.
    logic [3:0] m_level, m_press, m_rel, m_s1, m_s2;
    int         m_owner, m_ticks, m_ptr;
    int         press_seen, rel_seen;
    int         press_order[$];

    task automatic model_step();
        logic [3:0] s;
        m_press = '0;
        m_rel   = '0;
        if (rst) begin
            m_level = '0; m_owner = -1; m_ticks = 0; m_ptr = 0;
            m_s1 = '0; m_s2 = '0;
            return;
        end
`ifdef BTN_SYNC_EN
        s    = m_s2;
        m_s2 = m_s1;
        m_s1 = bif.btn;
`else
        s = bif.btn;
`endif
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int j;
                j = (m_ptr + k) % 4;
                if (m_owner < 0 && s[j] != m_level[j]) begin
                    m_owner = j;
                    m_ticks = 0;
                end
            end
        end else if (s[m_owner] == m_level[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
            m_ticks = 0;
        end else if (bif.tick_en) begin
            m_ticks++;
            if (m_ticks == LEN) begin
                if (m_level[m_owner]) m_rel[m_owner] = 1'b1;
                else                  m_press[m_owner] = 1'b1;
                m_level[m_owner] = ~m_level[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_ticks = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic check_cycle();
        logic [3:0] busy_exp, idx_exp;
        busy_exp = {3'b0, m_owner >= 0};
        idx_exp  = (m_owner >= 0) ? 4'(m_owner) : 4'(m_ptr);
        chk("level",   bif.btn_level,   m_level);
        chk("press",   bif.btn_press,   m_press);
        chk("release", bif.btn_release, m_rel);
        chk("busy",    {3'b0, bif.busy}, busy_exp);
        chk("idx",     {2'b0, bif.active_idx}, idx_exp);
        chk("onehot",  {3'b0, $onehot0(bif.btn_press | bif.btn_release)}, 4'd1);
        for (int i = 0; i < 4; i++) begin
            if (bif.btn_press[i]) begin
                press_seen++;
                press_order.push_back(i);
            end
            if (bif.btn_release[i]) rel_seen++;
        end
    endtask

    task automatic cyc(input logic tk);
        bif.tick_en = tk;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int n, input int per);
        for (int i = 0; i < n; i++) cyc((i % per) == per - 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        run(3, 10);
        rst = 1'b0;
        press_seen = 0;
        rel_seen   = 0;
        press_order.delete();
    endtask

    initial begin
        rst = 1'b1;
        bif.btn = '0;
        bif.tick_en = 1'b0;
        m_level = '0; m_press = '0; m_rel = '0; m_s1 = '0; m_s2 = '0;
        m_owner = -1; m_ticks = 0; m_ptr = 0;
        press_seen = 0; rel_seen = 0;
        @(negedge clk);

        // Reset state and single press.
        do_reset();
        chk("rst_level", bif.btn_level, 4'b0000);
        chk("rst_busy", {3'b0, bif.busy}, 4'd0);
        bif.btn = 4'b0001;
        run(60, 10);
        chk("s1_level", bif.btn_level, 4'b0001);
        chk("s1_npress", 4'(press_seen), 4'd1);

        // Bounce shorter than the debounce window aborts with pointer advanced.
        do_reset();
        bif.btn = 4'b0001;
        run(23, 10);
        bif.btn = 4'b0000;
        run(8, 10);
        chk("s2_level", bif.btn_level, 4'b0000);
        chk("s2_busy", {3'b0, bif.busy}, 4'd0);
        chk("s2_ptr", {2'b0, bif.active_idx}, 4'd1);
        chk("s2_npress", 4'(press_seen), 4'd0);

        // All four at once: served in order 0..3.
        do_reset();
        bif.btn = 4'b1111;
        run(240, 10);
        chk("s3_level", bif.btn_level, 4'b1111);
        chk("s3_npress", 4'(press_seen), 4'd4);
        for (int i = 0; i < 4; i++)
            chk("s3_order", (i < press_order.size()) ? 4'(press_order[i]) : 4'hf, 4'(i));

        // Release path.
        do_reset();
        bif.btn = 4'b0100;
        run(60, 10);
        chk("s4_level1", bif.btn_level, 4'b0100);
        bif.btn = 4'b0000;
        run(60, 10);
        chk("s4_level0", bif.btn_level, 4'b0000);
        chk("s4_nrel", 4'(rel_seen), 4'd1);

        // Reset in the middle of a count discards the grant.
        do_reset();
        bif.btn = 4'b0010;
        run(35, 10);
        rst = 1'b1;
        cyc(1'b0);
        rst = 1'b0;
        chk("s5_level_rst", bif.btn_level, 4'b0000);
        chk("s5_npress_rst", 4'(press_seen), 4'd0);
        run(60, 10);
        chk("s5_level", bif.btn_level, 4'b0010);
        chk("s5_npress", 4'(press_seen), 4'd1);

        // Random bouncing buttons, random strobe, occasional reset.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 7) == 0) bif.btn[$urandom_range(0, 3)] ^= 1'b1;
            rst = ($urandom_range(0, 599) == 0);
            cyc($urandom_range(0, 2) == 0);
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
